// File: rtl/i2_group_arbiter.sv
// Round-robin group arbiter: scans one request group per cycle and
// issues a single grant at a time over a valid/ready handshake.
module i2_group_arbiter #(
   parameter int NUM_GRP = 8,
   parameter int GRP_W   = 32,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [NUM_GRP*GRP_W-1:0]     req_vec,
   input  logic                         gnt_ready,
   output logic                         gnt_valid,
   output logic [$clog2(NUM_GRP)-1:0]   gnt_idx,
   output logic [NUM_GRP-1:0]           gnt_onehot,
   output logic                         any_req,
   output logic                         sweep_empty,
   output logic [CNT_W-1:0]             gnt_cnt
);

   localparam int IDX_W = $clog2(NUM_GRP);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_GRP - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      GRANT
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   scan_q, scan_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               vld_q, vld_d;
   logic               swp_q, swp_d;
   logic               any_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_GRP-1:0] grp_hit;
   logic               hit;

   function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      grp_hit = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         grp_hit[g] = |req_vec[g*GRP_W +: GRP_W];
      end
   end

   assign hit = grp_hit[ptr_q];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      scan_d  = scan_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      swp_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = SCAN;
               scan_d  = '0;
            end
         end
         SCAN: begin
            // a hit wins even when en has just dropped
            if (hit) begin
               idx_d   = ptr_q;
               vld_d   = 1'b1;
               state_d = GRANT;
            end else begin
               ptr_d = nxt(ptr_q);
               if (scan_q == LAST) begin
                  swp_d  = 1'b1;
                  scan_d = '0;
               end else begin
                  scan_d = scan_q + 1'b1;
               end
               if (!en) state_d = IDLE;
            end
         end
         GRANT: begin
            if (gnt_ready) begin
               vld_d   = 1'b0;
               ptr_d   = nxt(idx_q);
               scan_d  = '0;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               state_d = en ? SCAN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         swp_q   <= 1'b0;
         any_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         swp_q   <= swp_d;
         any_q   <= |req_vec;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_valid   = vld_q;
   assign gnt_idx     = idx_q;
   assign gnt_onehot  = vld_q ? (NUM_GRP'(1) << idx_q) : '0;
   assign any_req     = any_q;
   assign sweep_empty = swp_q;
   assign gnt_cnt     = cnt_q;

endmodule

// File: tb/tb_i2_group_arbiter.sv
// Directed bench for i2_group_arbiter: default instance plus a
// CNT_W=2 twin sharing the same stimulus for the saturation check.
module tb_i2_group_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [255:0] req_vec;
   logic         gnt_ready;
   logic         gnt_valid;
   logic [2:0]   gnt_idx;
   logic [7:0]   gnt_onehot;
   logic         any_req;
   logic         sweep_empty;
   logic [15:0]  gnt_cnt;

   logic         s_valid;
   logic [2:0]   s_idx;
   logic [7:0]   s_onehot;
   logic         s_any;
   logic         s_sweep;
   logic [1:0]   s_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   i2_group_arbiter u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req_vec     (req_vec),
      .gnt_ready   (gnt_ready),
      .gnt_valid   (gnt_valid),
      .gnt_idx     (gnt_idx),
      .gnt_onehot  (gnt_onehot),
      .any_req     (any_req),
      .sweep_empty (sweep_empty),
      .gnt_cnt     (gnt_cnt)
   );

   i2_group_arbiter #(.CNT_W(2)) u_sat (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req_vec     (req_vec),
      .gnt_ready   (gnt_ready),
      .gnt_valid   (s_valid),
      .gnt_idx     (s_idx),
      .gnt_onehot  (s_onehot),
      .any_req     (s_any),
      .sweep_empty (s_sweep),
      .gnt_cnt     (s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_gnt(input int maxe, output int e);
      e = 0;
      do begin
         tick(1);
         e++;
      end while (!gnt_valid && e < maxe);
   endtask

   function automatic logic [255:0] grp(input int g);
      logic [255:0] v;
      v = '0;
      v[g*32] = 1'b1;
      return v;
   endfunction

   initial begin
      int e;
      int p, first, second, vseen, aseen;
      rst_n = 1'b0; en = 1'b0; req_vec = '0; gnt_ready = 1'b0;
      tick(2);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_idx", gnt_idx, 0);
      chk("rst_onehot", gnt_onehot, 0);
      chk("rst_any", any_req, 0);
      chk("rst_sweep", sweep_empty, 0);
      chk("rst_cnt", gnt_cnt, 0);

      // latency: hit at distance 5 from ptr 0
      rst_n = 1'b1; en = 1'b1;
      req_vec = '0; req_vec[5*32+17] = 1'b1;
      wait_gnt(20, e);
      chk("lat_edges", e, 7);
      chk("lat_idx", gnt_idx, 5);
      chk("lat_onehot", gnt_onehot, 8'h20);
      chk("lat_any", any_req, 1);
      gnt_ready = 1'b1;
      tick(1);
      chk("lat_hs_valid", gnt_valid, 0);
      chk("lat_hs_cnt", gnt_cnt, 1);
      // scan continues one miss at ptr 6, then idles with ptr 7
      en = 1'b0; gnt_ready = 1'b0; req_vec = '0;
      tick(2);
      chk("idle_valid", gnt_valid, 0);
      chk("idle_any", any_req, 0);

      // wrap: ptr 7 with groups 7 and 0
      req_vec = grp(7) | grp(0); en = 1'b1;
      wait_gnt(20, e);
      chk("wrap_edges", e, 2);
      chk("wrap_idx7", gnt_idx, 7);
      chk("wrap_oh7", gnt_onehot, 8'h80);
      gnt_ready = 1'b1;
      tick(1);
      chk("wrap_hs_valid", gnt_valid, 0);
      chk("wrap_hs_cnt", gnt_cnt, 2);
      tick(1);
      chk("wrap_valid0", gnt_valid, 1);
      chk("wrap_idx0", gnt_idx, 0);
      chk("wrap_oh0", gnt_onehot, 8'h01);
      tick(1);
      chk("sat_cnt3", gnt_cnt, 3);
      chk("sat_small3", s_cnt, 3);
      wait_gnt(20, e);
      chk("wrap2_valid", gnt_valid, 1);
      chk("wrap2_idx", gnt_idx, 7);
      tick(1);
      chk("sat_cnt4", gnt_cnt, 4);
      chk("sat_small_hold", s_cnt, 3);

      // round robin between groups 2 and 6
      req_vec = grp(2) | grp(6);
      for (int k = 0; k < 4; k++) begin
         wait_gnt(20, e);
         chk("rr_valid", gnt_valid, 1);
         chk("rr_idx", gnt_idx, (k % 2 == 0) ? 2 : 6);
         chk("rr_onehot", gnt_onehot, (k % 2 == 0) ? 8'h04 : 8'h40);
         tick(1);
         chk("rr_hs_valid", gnt_valid, 0);
         chk("rr_cnt", gnt_cnt, 5 + k);
      end
      chk("rr_small_sat", s_cnt, 3);

      // reset while a grant on group 3 is stalled
      gnt_ready = 1'b0; req_vec = grp(3);
      wait_gnt(20, e);
      chk("mid_valid", gnt_valid, 1);
      chk("mid_idx", gnt_idx, 3);
      tick(3);
      chk("mid_hold", gnt_idx, 3);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_valid", gnt_valid, 0);
      chk("mid_rst_idx", gnt_idx, 0);
      chk("mid_rst_oh", gnt_onehot, 0);
      chk("mid_rst_cnt", gnt_cnt, 0);
      chk("mid_rst_small", s_cnt, 0);
      chk("mid_rst_any", any_req, 0);
      // back in IDLE with ptr 0: stays put until en, then grants group 0
      rst_n = 1'b1; en = 1'b0; req_vec = grp(0);
      tick(2);
      chk("post_rst_idle", gnt_valid, 0);
      en = 1'b1;
      wait_gnt(20, e);
      chk("post_rst_edges", e, 2);
      chk("post_rst_idx", gnt_idx, 0);
      gnt_ready = 1'b1;
      tick(1);
      chk("post_rst_cnt", gnt_cnt, 1);

      // stall on group 1 while its request and en drop
      gnt_ready = 1'b0; req_vec = grp(1);
      wait_gnt(20, e);
      chk("stall_edges", e, 1);
      chk("stall_idx0", gnt_idx, 1);
      req_vec = '0; en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("stall_held", {gnt_valid, gnt_idx}, {1'b1, 3'd1});
      end
      chk("stall_any", any_req, 0);
      gnt_ready = 1'b1;
      tick(1);
      chk("stall_hs_valid", gnt_valid, 0);
      chk("stall_hs_cnt", gnt_cnt, 2);
      gnt_ready = 1'b0; req_vec = grp(4);
      tick(3);
      chk("stall_idle", gnt_valid, 0);

      // empty sweep: 20 cycles with nothing requested
      req_vec = '0; en = 1'b1;
      p = 0; first = 0; second = 0; vseen = 0; aseen = 0;
      for (int t = 1; t <= 20; t++) begin
         tick(1);
         if (sweep_empty) begin
            p++;
            if (p == 1) first = t;
            else if (p == 2) second = t;
         end
         if (gnt_valid) vseen = 1;
         if (any_req) aseen = 1;
      end
      chk("empty_pulses", p, 2);
      chk("empty_first", first, 9);
      chk("empty_second", second, 17);
      chk("empty_valid", vseen, 0);
      chk("empty_any", aseen, 0);
      chk("empty_cnt", gnt_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
